// File: rtl/bp_pkg.sv
// Shared constants, sequencer state and counter arithmetic for the branch predictor table.
package bp_pkg;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  typedef enum logic {INIT, READY} seq_state_e;

  // Weakly-not-taken: the value just below the taken threshold.
  function automatic int weak_nt(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  function automatic int sat_next(input int cnt, input logic taken, input int cnt_w);
    int max_cnt;
    max_cnt = (1 << cnt_w) - 1;
    if (taken) return (cnt >= max_cnt) ? max_cnt : cnt + 1;
    else       return (cnt == 0) ? 0 : cnt - 1;
  endfunction

endpackage

// File: rtl/bp_index_hash.sv
// PC/GHR to table index: bimodal or gshare.
// Latency: combinational.
// Backpressure: none.
module bp_index_hash
  import bp_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int IDX_W = 6,
  parameter int GHR_W = 6,
  parameter int MODE  = MODE_BIMODAL
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [GHR_W-1:0] ghr,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] ghr_fold;
  logic             unused_bits;

  assign pc_idx      = pc[IDX_W+1:2];
  assign unused_bits = ^{pc[PC_W-1:IDX_W+2], pc[1:0], ghr, ghr_fold};

  generate
    if (GHR_W >= IDX_W) begin : g_trunc
      assign ghr_fold = ghr[IDX_W-1:0];
    end else begin : g_zext
      assign ghr_fold = {{(IDX_W-GHR_W){1'b0}}, ghr};
    end

    if (MODE == MODE_GSHARE) begin : g_gshare
      assign idx = pc_idx ^ ghr_fold;
    end else begin : g_bimodal
      assign idx = pc_idx;
    end
  endgenerate

endmodule

// File: rtl/branch_predictor_table.sv
// Saturating-counter branch predictor table with init sweep and resolve-stage training.
// Latency: prediction 1 cycle after lookup; update writes at the request edge.
// Backpressure: none; lookups/updates during the init sweep are dropped, busy_o flags it.
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int IDX_W = 6,
  parameter int CNT_W = 2,
  parameter int GHR_W = 6,
  parameter int MODE  = MODE_BIMODAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid_i,
  input  logic [PC_W-1:0]  pred_pc_i,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  output logic [IDX_W-1:0] pred_idx_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  output logic             busy_o,
  output logic [GHR_W-1:0] ghr_o
);

  localparam int               DEPTH    = 2**IDX_W;
  localparam logic [CNT_W-1:0] WEAK_NT  = CNT_W'(weak_nt(CNT_W));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W:0]   ghr_shift;
  logic             unused_ghr_msb;
  logic [CNT_W-1:0] cnt_mem [DEPTH];
  logic             ready;
  logic             lookup_en;
  logic             update_en;
  logic             bypass;
  logic [IDX_W-1:0] lkp_idx;
  logic [CNT_W-1:0] lkp_cnt;
  logic [CNT_W-1:0] upd_cnt_new;

  always_ff @(posedge clk) begin
    if (reset) state_q <= INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && ptr_q == LAST_IDX) state_d = READY;
  end

  always_comb begin
    busy_o = (state_q == INIT);
    ready  = (state_q == READY);
  end

  always_ff @(posedge clk) begin
    if (reset)                 ptr_q <= '0;
    else if (state_q == INIT)  ptr_q <= ptr_q + 1'b1;
  end

  assign lookup_en = pred_valid_i && ready;
  assign update_en = upd_valid_i && ready;

  // Hash sees the GHR before this cycle's update shifts it.
  bp_index_hash #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W),
    .GHR_W (GHR_W),
    .MODE  (MODE)
  ) u_hash (
    .pc  (pred_pc_i),
    .ghr (ghr_q),
    .idx (lkp_idx)
  );

  assign upd_cnt_new = CNT_W'(sat_next(int'(cnt_mem[upd_idx_i]), upd_taken_i, CNT_W));
  assign bypass      = update_en && (lkp_idx == upd_idx_i);
  assign lkp_cnt     = bypass ? upd_cnt_new : cnt_mem[lkp_idx];

  always_ff @(posedge clk) begin
    if (state_q == INIT) cnt_mem[ptr_q]     <= WEAK_NT;
    else if (update_en)  cnt_mem[upd_idx_i] <= upd_cnt_new;
  end

  assign ghr_shift      = {ghr_q, upd_taken_i};
  assign unused_ghr_msb = ghr_shift[GHR_W];

  always_ff @(posedge clk) begin
    if (reset)          ghr_q <= '0;
    else if (update_en) ghr_q <= ghr_shift[GHR_W-1:0];
  end

  assign ghr_o = ghr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid_o <= 1'b0;
      pred_taken_o <= 1'b0;
      pred_idx_o   <= '0;
    end else begin
      pred_valid_o <= lookup_en;
      if (lookup_en) begin
        pred_taken_o <= lkp_cnt[CNT_W-1];
        pred_idx_o   <= lkp_idx;
      end
    end
  end

endmodule

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
Parametrised table of saturating-counter branch predictors for the fetch stage. It is indexed by PC, with an optional gshare hashing of a global history register (GHR). Prediction is a registered lookup with 1-cycle latency. Training arrives on a separate resolve-stage update port. After reset, an init sequencer sweeps the table before the block accepts lookups.

Parameters:
PC_W, 32, fetch PC width
IDX_W, 6, index width; table holds 2**IDX_W entries
CNT_W, 2, saturating counter width (>=2)
GHR_W, 6, global history length (>=1)
MODE, 0, 0 = bimodal (PC index only), 1 = gshare (PC index XOR GHR)

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
pred_valid_i  in  1  lookup request this cycle
pred_pc_i  in  PC_W  lookup PC
pred_valid_o  out  1  prediction valid (1 cycle after request)
pred_taken_o  out  1  predicted direction
pred_idx_o  out  IDX_W  index used; fetch carries it to resolve for update
upd_valid_i  in  1  update request
upd_idx_i  in  IDX_W  entry to train
upd_taken_i  in  1  resolved direction
busy_o  out  1  init sweep in progress
ghr_o  out  GHR_W  current global history

Behaviour:
- Reset and init:
  - Reset is synchronous, active-high, on clk.
  - While reset is high: sequencer enters INIT with sweep pointer 0; busy_o=1; pred_valid_o=0; pred_taken_o=0; pred_idx_o=0; ghr_o=0.
  - INIT: each cycle writes entry[ptr] = WEAK_NT, where WEAK_NT = 2**(CNT_W-1)-1 (binary 01 for CNT_W=2), then ptr++.
  - After the last entry is written, the next state is READY and busy_o drops. busy_o is high for exactly 2**IDX_W cycles after reset deasserts.
  - Reset asserted mid-sweep restarts the sweep from 0.
- During INIT: lookups are ignored (pred_valid_o stays 0); updates are dropped; GHR does not shift.
- Index function:
  - pc_idx = pred_pc_i[IDX_W+1:2] (word-aligned PCs).
  - MODE 0: idx = pc_idx.
  - MODE 1: idx = pc_idx XOR G, where G is the GHR truncated or zero-extended to IDX_W.
  - GHR bit 0 holds the newest outcome.
- Lookup (READY):
  - Request at cycle T → at T+1: pred_valid_o=1; pred_taken_o = MSB of entry[idx]; pred_idx_o = idx.
  - No request → pred_valid_o=0 at T+1; other outputs hold their last value.
  - Back-to-back requests are accepted every cycle; there is no stall.
- Update (READY):
  - Sequencing: upd_valid_i at T writes entry[upd_idx_i] at the T clock edge.
  - Taken increments the counter, saturating at 2**CNT_W-1; not-taken decrements it, saturating at 0.
  - The GHR shifts: {ghr[GHR_W-2:0], upd_taken_i}. History is non-speculative.
- Simultaneous lookup and update at cycle T:
  - Lookup index is computed with the GHR value before the T update.
  - If lookup idx == upd_idx_i, pred_taken_o uses the post-update counter value (write-through bypass).
  - Different indices are independent.
- Only one update port exists; there are no update collisions.

Decomposition:
- Package bp_pkg:
  - WEAK_NT constant function of CNT_W.
  - mode encoding constants MODE_BIMODAL=0, MODE_GSHARE=1.
  - sequencer state typedef {INIT, READY}.
  - function sat_next(cnt, taken).
- Sub-module bp_index_hash: combinational PC/GHR-to-index. It keeps the hash swappable.
- Counter array, bypass and init sequencer stay in the top module.

Test Plan:
- Reset 1 cycle, then idle → busy_o=1 for 64 cycles, then 0. Lookup pc 0x100 → pred_valid_o=1, pred_taken_o=0, pred_idx_o=0.
- MODE 0 saturation on idx 5:
  - 2 taken updates → lookup pc 0x14 gives taken=1; a 3rd taken leaves the counter at 3.
  - 1 not-taken → still taken=1.
  - 2 more not-taken → taken=0; a 4th not-taken leaves the counter at 0.
- Bypass: idx 3 at 01. Same cycle: upd idx 3 taken and lookup pc 0x0C → next-cycle pred_taken_o=1.
- MODE 1: after updates taken, not-taken, taken, ghr_o=6'b000101 → lookup pc 0x0 gives pred_idx_o=5. Lookup pc 0x14 gives pred_idx_o=0.
- Reset re-asserted 20 cycles into the sweep → busy_o stays 1 and deasserts exactly 64 cycles after the second reset release; all entries read WEAK_NT.
- During busy_o=1: upd_valid_i idx 7 taken and pred_valid_i → pred_valid_o=0, ghr_o=0. After init, idx 7 predicts 0.
